// File: rtl/fp16_result_serializer_pkg.sv
// Shared FP16 constants, serializer state encoding and the saturate/flush packer.
// Latency: none, pure declarations and a combinational helper function.
// Backpressure: not applicable.
package fp16_pkg;

    localparam int          FP16_EXP_W   = 5;
    localparam int          FP16_MAN_W   = 10;
    localparam int          FP16_BIAS    = 15;
    localparam int          FP16_EXP_MAX = 31;
    localparam logic [14:0] FP16_MAXFIN  = 15'h7BFF;
    localparam logic [14:0] FP16_INF     = 15'h7C00;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } ser_state_t;

    typedef struct packed {
        logic        ovf;
        logic        unf;
        logic [15:0] word;
    } pack_res_t;

    // The multiplier hands over a 7-bit two's complement biased exponent; anything
    // outside 1..30 cannot be represented as a normal FP16 and is clamped.
    function automatic pack_res_t pack_fp16(input logic       sign,
                                            input logic [6:0] exp_raw,
                                            input logic [9:0] man,
                                            input bit         sat_to_inf);
        pack_res_t r;
        int        e;
        e     = int'($signed(exp_raw));
        r.ovf = 1'b0;
        r.unf = 1'b0;
        if (e >= FP16_EXP_MAX) begin
            r.ovf  = 1'b1;
            r.word = {sign, (sat_to_inf ? FP16_INF : FP16_MAXFIN)};
        end else if (e <= 0) begin
            r.unf  = 1'b1;
            r.word = {sign, 15'h0000};
        end else begin
            r.word = {sign, exp_raw[FP16_EXP_W-1:0], man[FP16_MAN_W-1:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/fp16_result_serializer_if.sv
// Bundles the product-field input handshake and the byte output handshake.
// Latency: none, wiring only.
// Backpressure: in_ready throttles the producer, out_ready throttles the byte stream.
interface fp16_result_serializer_if;

    logic       in_valid;
    logic       in_ready;
    logic       in_sign;
    logic [6:0] in_exp;
    logic [9:0] in_man;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       out_last;

    modport slave (
        input  in_valid, in_sign, in_exp, in_man, out_ready,
        output in_ready, out_valid, out_byte, out_last
    );

    modport master (
        output in_valid, in_sign, in_exp, in_man, out_ready,
        input  in_ready, out_valid, out_byte, out_last
    );

endinterface

// File: rtl/fp16_result_serializer_fifo.sv
// Small synchronous FIFO with count-based full/empty and first-word-fall-through read data.
// Latency: a pushed word is visible on rdata_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module fp16_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage array, never reset: only slots between the pointers are meaningful.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two; count gives full/empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      cnt_q <= cnt_q + CNT_W'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/fp16_result_serializer.sv
// Saturates/flushes raw product fields to FP16, buffers them, streams each word low byte first.
// Latency: word accepted at edge N shows its low byte from edge N+1 when idle; 1 byte/cycle sustained.
// Backpressure: in_ready = !rst && !fifo_full (no path from out_ready); bytes hold while !out_ready.
module fp16_result_serializer #(
    parameter int FIFO_DEPTH = 2,
    parameter int SAT_TO_INF = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    fp16_result_serializer_if.slave        bus,
    input  logic                           clr_flags,
    output logic                           ovf_sticky,
    output logic                           unf_sticky,
    output logic                           busy
);
    import fp16_pkg::*;

    pack_res_t   pk;
    logic        accept;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [15:0] fifo_rdata;

    ser_state_t  state_q, state_d;
    logic [15:0] hold_q, hold_d;
    logic [7:0]  byte_q, byte_d;
    logic        last_q, last_d;
    logic        vld_q, vld_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;

    assign pk           = pack_fp16(bus.in_sign, bus.in_exp, bus.in_man, SAT_TO_INF != 0);
    assign bus.in_ready = !rst && !fifo_full;
    assign accept       = bus.in_valid && bus.in_ready;

    fp16_sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (accept),
        .wdata_i (pk.word),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Serializer next state: pop straight into the low byte so consecutive words have no bubble.
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        byte_d   = byte_q;
        last_d   = last_q;
        vld_d    = vld_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_rdata;
                    byte_d   = fifo_rdata[7:0];
                    last_d   = 1'b0;
                    vld_d    = 1'b1;
                    state_d  = S_LO;
                end
            end
            S_LO: begin
                if (bus.out_ready) begin
                    byte_d  = hold_q[15:8];
                    last_d  = 1'b1;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (bus.out_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        hold_d   = fifo_rdata;
                        byte_d   = fifo_rdata[7:0];
                        last_d   = 1'b0;
                        state_d  = S_LO;
                    end else begin
                        vld_d    = 1'b0;
                        byte_d   = 8'h00;
                        last_d   = 1'b0;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sticky flags: a set from an accepted word overrides a same-cycle clear.
    always_comb begin
        ovf_d = clr_flags ? 1'b0 : ovf_q;
        unf_d = clr_flags ? 1'b0 : unf_q;
        if (accept && pk.ovf) ovf_d = 1'b1;
        if (accept && pk.unf) unf_d = 1'b1;
    end

    // State and output registers; reset drops any partially sent word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hold_q  <= 16'h0000;
            byte_q  <= 8'h00;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            byte_q  <= byte_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.out_byte  = byte_q;
    assign bus.out_last  = last_q;
    assign ovf_sticky    = ovf_q;
    assign unf_sticky    = unf_q;
    assign busy          = !fifo_empty || (state_q != S_IDLE);

endmodule

// File: tb/tb_fp16_result_serializer.sv
// Self-checking bench: two instances (SAT_TO_INF=1 and 0) driven in lockstep.
// Latency: reference model predicts the byte stream; cycle stamps check back-to-back output.
// Backpressure: out_ready is held low, pulsed and randomized across the scenarios.
module tb_fp16_result_serializer;

    logic clk = 1'b0;
    logic rst;
    logic clr_flags;
    logic ovf0, unf0, busy0, ovf1, unf1, busy1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    logic [8:0] exp0 [$];
    logic [8:0] exp1 [$];
    logic [8:0] obs0 [$];
    logic [8:0] obs1 [$];
    int         stamp0 [$];

    fp16_result_serializer_if bus0 ();
    fp16_result_serializer_if bus1 ();

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.in_sign   = bus0.in_sign;
    assign bus1.in_exp    = bus0.in_exp;
    assign bus1.in_man    = bus0.in_man;
    assign bus1.out_ready = bus0.out_ready;

    fp16_result_serializer #(.FIFO_DEPTH(2), .SAT_TO_INF(1)) dut (
        .clk(clk), .rst(rst), .bus(bus0), .clr_flags(clr_flags),
        .ovf_sticky(ovf0), .unf_sticky(unf0), .busy(busy0));

    fp16_result_serializer #(.FIFO_DEPTH(2), .SAT_TO_INF(0)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus1), .clr_flags(clr_flags),
        .ovf_sticky(ovf1), .unf_sticky(unf1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every byte actually transferred on each output.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus0.out_valid && bus0.out_ready) begin
                obs0.push_back({bus0.out_last, bus0.out_byte});
                stamp0.push_back(cyc);
            end
            if (bus1.out_valid && bus1.out_ready) obs1.push_back({bus1.out_last, bus1.out_byte});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic int sexp(input logic [6:0] e7);
        int e;
        e = int'(e7);
        if (e >= 64) e = e - 128;
        return e;
    endfunction

    function automatic logic [15:0] model_word(input logic s, input logic [6:0] e7,
                                               input logic [9:0] m, input bit inf);
        int e, mag, sv;
        e  = sexp(e7);
        sv = s ? 32768 : 0;
        if (e >= 31)     mag = inf ? 31 * 1024 : 30 * 1024 + 1023;
        else if (e <= 0) mag = 0;
        else             mag = e * 1024 + int'(m);
        return 16'(sv + mag);
    endfunction

    function automatic bit model_ovf(input logic [6:0] e7);
        return sexp(e7) >= 31;
    endfunction

    function automatic bit model_unf(input logic [6:0] e7);
        return sexp(e7) <= 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic expect_word(input logic s, input logic [6:0] e, input logic [9:0] m);
        logic [15:0] w0, w1;
        w0 = model_word(s, e, m, 1'b1);
        w1 = model_word(s, e, m, 1'b0);
        exp0.push_back({1'b0, w0[7:0]});
        exp0.push_back({1'b1, w0[15:8]});
        exp1.push_back({1'b0, w1[7:0]});
        exp1.push_back({1'b1, w1[15:8]});
    endtask

    task automatic send_word(input logic s, input logic [6:0] e, input logic [9:0] m);
        bit ok;
        ok = 1'b0;
        bus0.in_sign  = s;
        bus0.in_exp   = e;
        bus0.in_man   = m;
        bus0.in_valid = 1'b1;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (bus0.in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus0.in_valid = 1'b0;
        if (ok) expect_word(s, e, m);
        else begin
            checks++; errors++;
            $display("FAIL accept_timeout: in_ready=%b required 1 within 500 cycles", bus0.in_ready);
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < 400 && (obs0.size() < n || obs1.size() < n); i++) @(negedge clk);
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_q();
        exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete(); stamp0.delete();
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1; clr_flags = 1'b1;
        @(posedge clk); #1; clr_flags = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; clr_flags = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_sign = 1'b0; bus0.in_exp = '0; bus0.in_man = '0;
        bus0.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({bus0.out_valid, bus0.out_last, bus0.out_byte} !== 10'h000) begin
            errors++; $display("FAIL reset_out0: valid/last/byte=%h required 000", {bus0.out_valid, bus0.out_last, bus0.out_byte}); end
        checks++; if ({bus1.out_valid, bus1.out_last, bus1.out_byte} !== 10'h000) begin
            errors++; $display("FAIL reset_out1: valid/last/byte=%h required 000", {bus1.out_valid, bus1.out_last, bus1.out_byte}); end
        checks++; if ({ovf0, unf0, busy0, ovf1, unf1, busy1} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: ovf/unf/busy=%b required 000000", {ovf0, unf0, busy0, ovf1, unf1, busy1}); end
        checks++; if (bus0.in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready: got %b required 0 during reset", bus0.in_ready); end
        @(posedge clk); #1; rst = 1'b0; bus0.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus0.in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset_in_ready: got %b required 1", bus0.in_ready); end
    endtask

    task automatic test_packing_table();
        logic [17:0] tbl [7];
        logic s; logic [6:0] e; logic [9:0] m;
        tbl = '{{1'b0, 7'd16, 10'h200}, {1'b0, 7'd30, 10'h3FF}, {1'b0, 7'd0, 10'h155},
                {1'b1, 7'h7E, 10'h3FF}, {1'b0, 7'd31, 10'h005}, {1'b1, 7'd1, 10'h001},
                {1'b1, 7'h40, 10'h2AA}};
        for (int i = 0; i < 7; i++) begin
            s = tbl[i][17]; e = tbl[i][16:10]; m = tbl[i][9:0];
            pulse_clr();
            clear_q();
            send_word(s, e, m);
            drain(2);
            checks++;
            if (obs0.size() != 2 || obs1.size() != 2) begin
                errors++; $display("FAIL pack_count[%0d]: bytes=%0d/%0d required 2", i, obs0.size(), obs1.size());
            end else begin
                if ({obs0[1], obs0[0]} !== {exp0[1], exp0[0]}) begin
                    errors++; $display("FAIL pack_inf[%0d]: got %h required %h", i, {obs0[1], obs0[0]}, {exp0[1], exp0[0]}); end
                checks++;
                if ({obs1[1], obs1[0]} !== {exp1[1], exp1[0]}) begin
                    errors++; $display("FAIL pack_maxfin[%0d]: got %h required %h", i, {obs1[1], obs1[0]}, {exp1[1], exp1[0]}); end
            end
            checks++;
            if ({ovf0, unf0, ovf1, unf1} !== {model_ovf(e), model_unf(e), model_ovf(e), model_unf(e)}) begin
                errors++; $display("FAIL pack_flags[%0d]: ovf/unf=%b required %b", i, {ovf0, unf0, ovf1, unf1},
                                   {model_ovf(e), model_unf(e), model_ovf(e), model_unf(e)}); end
        end
    endtask

    task automatic test_overflow_flags();
        pulse_clr();
        clear_q();
        send_word(1'b1, 7'd33, 10'h012);
        drain(2);
        checks++;
        if (obs0.size() != 2 || obs1.size() != 2 || {obs0[1], obs0[0], obs1[1], obs1[0]} !== {exp0[1], exp0[0], exp1[1], exp1[0]}) begin
            errors++; $display("FAIL ovf_bytes: got %0d/%0d bytes, first=%h required %h", obs0.size(), obs1.size(),
                               (obs0.size() > 1) ? {obs0[1], obs0[0]} : 18'h0, {exp0[1], exp0[0]}); end
        checks++; if ({ovf0, ovf1} !== 2'b11) begin
            errors++; $display("FAIL ovf_set: got %b required 11", {ovf0, ovf1}); end
        pulse_clr();
        @(negedge clk);
        checks++; if ({ovf0, ovf1} !== 2'b00) begin
            errors++; $display("FAIL ovf_clear: got %b required 00", {ovf0, ovf1}); end
        @(posedge clk); #1;
        clr_flags = 1'b1; bus0.in_sign = 1'b0; bus0.in_exp = 7'd50; bus0.in_man = 10'h0; bus0.in_valid = 1'b1;
        @(negedge clk);
        checks++; if (bus0.in_ready !== 1'b1) begin
            errors++; $display("FAIL ovf_race_ready: got %b required 1", bus0.in_ready); end
        @(posedge clk); #1;
        clr_flags = 1'b0; bus0.in_valid = 1'b0;
        expect_word(1'b0, 7'd50, 10'h0);
        @(negedge clk);
        checks++; if ({ovf0, ovf1} !== 2'b11) begin
            errors++; $display("FAIL ovf_set_wins: got %b required 11", {ovf0, ovf1}); end
        drain(4);
    endtask

    task automatic test_random();
        logic s; logic [6:0] e; logic [9:0] m;
        bit done, eo, eu;
        done = 1'b0; eo = 1'b0; eu = 1'b0;
        pulse_clr();
        clear_q();
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    s = 1'($urandom_range(0, 1));
                    e = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 32));
                    m = 10'($urandom);
                    if (model_ovf(e)) eo = 1'b1;
                    if (model_unf(e)) eu = 1'b1;
                    send_word(s, e, m);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus0.out_ready = ($urandom_range(0, 3) != 0);
                end
                @(posedge clk); #1;
                bus0.out_ready = 1'b1;
            end
        join
        drain(exp0.size());
        checks++;
        if (obs0.size() != exp0.size() || obs1.size() != exp1.size()) begin
            errors++; $display("FAIL rand_count: got %0d/%0d bytes required %0d", obs0.size(), obs1.size(), exp0.size()); end
        for (int i = 0; i < exp0.size() && i < obs0.size() && i < obs1.size(); i++) begin
            checks++;
            if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
                errors++; $display("FAIL rand_byte[%0d]: got %h/%h required %h/%h", i, obs0[i], obs1[i], exp0[i], exp1[i]); end
        end
        checks++; if ({ovf0, unf0, ovf1, unf1} !== {eo, eu, eo, eu}) begin
            errors++; $display("FAIL rand_flags: got %b required %b", {ovf0, unf0, ovf1, unf1}, {eo, eu, eo, eu}); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1; bus0.out_ready = 1'b0;
        clear_q();
        send_word(1'b0, 7'd5,  10'h0A1);
        send_word(1'b1, 7'd12, 10'h3C3);
        send_word(1'b0, 7'd29, 10'h27E);
        bus0.in_sign = 1'b1; bus0.in_exp = 7'd20; bus0.in_man = 10'h155; bus0.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus0.in_ready !== 1'b0) begin
            errors++; $display("FAIL full_in_ready: got %b required 0 with FIFO full", bus0.in_ready); end
        @(posedge clk); #1; bus0.out_ready = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (bus0.in_ready) begin @(posedge clk); #1; ok = 1'b1; end
        end
        bus0.in_valid = 1'b0;
        expect_word(1'b1, 7'd20, 10'h155);
        drain(8);
        checks++;
        if (!ok || obs0.size() != 8 || obs1.size() != 8) begin
            errors++; $display("FAIL b2b_count: accepted=%b bytes=%0d/%0d required 1 and 8", ok, obs0.size(), obs1.size()); end
        for (int i = 0; i < 8 && i < obs0.size() && i < obs1.size(); i++) begin
            checks++;
            if (obs0[i] !== exp0[i] || obs1[i] !== exp1[i]) begin
                errors++; $display("FAIL b2b_byte[%0d]: got %h/%h required %h/%h", i, obs0[i], obs1[i], exp0[i], exp1[i]); end
        end
        for (int i = 1; i < 8 && i < stamp0.size(); i++) begin
            checks++;
            if (stamp0[i] !== stamp0[i-1] + 1) begin
                errors++; $display("FAIL b2b_gap[%0d]: byte at cycle %0d required %0d", i, stamp0[i], stamp0[i-1] + 1); end
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1; bus0.out_ready = 1'b0;
        clear_q();
        send_word(1'b0, 7'd40, 10'h001);
        send_word(1'b1, 7'd0,  10'h002);
        @(negedge clk);
        checks++; if (bus0.out_valid !== 1'b1 || busy0 !== 1'b1) begin
            errors++; $display("FAIL mid_pre: valid/busy=%b%b required 11", bus0.out_valid, busy0); end
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus0.out_valid, bus0.out_last, bus0.out_byte, busy0, ovf0, unf0, busy1, ovf1, unf1} !== 16'h0000) begin
            errors++; $display("FAIL mid_reset_state: valid/last/byte/busy/flags=%h required 0000",
                               {bus0.out_valid, bus0.out_last, bus0.out_byte, busy0, ovf0, unf0, busy1, ovf1, unf1}); end
        checks++; if (bus0.in_ready !== 1'b1) begin
            errors++; $display("FAIL mid_in_ready: got %b required 1", bus0.in_ready); end
        clear_q();
        @(posedge clk); #1; bus0.out_ready = 1'b1;
        send_word(1'b0, 7'd15, 10'h000);
        drain(2);
        repeat (5) @(negedge clk);
        checks++;
        if (obs0.size() != 2 || obs1.size() != 2) begin
            errors++; $display("FAIL mid_count: got %0d/%0d bytes required 2", obs0.size(), obs1.size());
        end else if ({obs0[1], obs0[0]} !== {9'h13C, 9'h000} || {obs1[1], obs1[0]} !== {9'h13C, 9'h000}) begin
            errors++; $display("FAIL mid_fresh_word: got %h/%h required %h", {obs0[1], obs0[0]}, {obs1[1], obs1[0]}, {9'h13C, 9'h000});
        end
    endtask

    initial begin
        test_reset();
        test_packing_table();
        test_overflow_flags();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp16_result_serializer.md
Name: fp16_result_serializer

Overview:
- Downstream stage of the FP16 logarithmic multiplier.
- Takes the multiplier's raw product fields (sign, extended signed exponent, mantissa) over a valid/ready handshake and saturates or flushes them to legal FP16.
- Buffers packed words in a small FIFO, then streams each word out as two bytes, low byte first, on the 8-bit output pins with a valid/ready byte handshake.
- Replaces the ad-hoc byte-output logic with a defined, back-pressurable interface.

Parameters:
- FIFO_DEPTH, 2, number of buffered packed words; power of two, minimum 2.
- SAT_TO_INF, 1, overflow result: 1 gives ±Inf (exp 0x1F, man 0); 0 gives ±max finite (exp 0x1E, man 0x3FF).

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  product fields valid
- in_ready  output  1  stage can accept a word
- in_sign  input  1  product sign
- in_exp  input  7  biased product exponent, two's complement (-64..63)
- in_man  input  10  product mantissa, hidden bit excluded
- out_valid  output  1  out_byte valid
- out_ready  input  1  consumer takes out_byte
- out_byte  output  8  serialized result byte
- out_last  output  1  high when out_byte is the high byte (bits 15:8)
- clr_flags  input  1  clear sticky flags
- ovf_sticky  output  1  an overflowed word was accepted
- unf_sticky  output  1  an underflowed/zero word was accepted
- busy  output  1  FIFO non-empty or serializer active

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (rst). All state is sampled on the rising edge of clk.
- Reset: out_valid=0, out_byte=0, out_last=0, ovf_sticky=0, unf_sticky=0, busy=0. FIFO is emptied and the FSM goes to S_IDLE. in_ready=0 while rst=1.
- Reset mid-operation: buffered words and any partially sent word are discarded. No byte is emitted after reset.
- Packing is combinational at the FIFO input, using signed in_exp:
  - in_exp >= 31: overflow, word per SAT_TO_INF, sign kept.
  - in_exp <= 0: underflow, word = {in_sign, 15'h0}.
  - otherwise: word = {in_sign, in_exp[4:0], in_man}.
- Accept: in_valid && in_ready at an edge writes the packed word into the FIFO.
- in_ready = !rst && !fifo_full. It has no combinational path from out_ready. When the FIFO is full, no word is accepted even if a pop happens in the same cycle.
- FIFO: write/read pointers wrap modulo FIFO_DEPTH. Count-based full/empty.
- Sticky flags: set on acceptance of an overflowed or underflowed word. clr_flags clears them. If a set and a clear happen in the same cycle, the set wins.
- Serializer FSM:
  - S_IDLE: if the FIFO is non-empty, pop into a 16-bit holding register, drive out_byte=word[7:0], out_last=0, out_valid=1, go to S_LO.
  - S_LO: on out_ready, drive out_byte=word[15:8], out_last=1, go to S_HI.
  - S_HI: on out_ready, if the FIFO is non-empty, pop the next word and drive its low byte (S_LO, no bubble). Otherwise out_valid=0, go to S_IDLE.
- Hold rule: while out_valid && !out_ready, out_byte and out_last are stable.
- Latency: a word accepted at edge N drives out_valid high from edge N+1, when the serializer is idle. Sustained throughput is 1 byte per cycle with out_ready held high.
- busy = !fifo_empty || state != S_IDLE.

Decomposition:
- Package fp16_pkg:
  - FP16_EXP_W=5, FP16_MAN_W=10, FP16_BIAS=15
  - FP16_EXP_MAX=31, FP16_MAXFIN=15'h7BFF, FP16_INF=15'h7C00
  - serializer state enum {S_IDLE, S_LO, S_HI}
- Sub-module fp16_sync_fifo: parameterized width/depth, synchronous active-high reset, push/pop/full/empty.

Test Plan:
- sign=0, exp=16, man=0x200 -> word 0x4200. Bytes 0x00 (out_last=0) then 0x42 (out_last=1). Both flags stay 0.
- sign=1, exp=33, SAT_TO_INF=1 -> 0xFC00, bytes 0x00, 0xFC, ovf_sticky=1. Pulse clr_flags -> 0. Pulse clr_flags in the same cycle as a new overflow acceptance -> flag stays 1.
- Boundaries:
  - exp=30, man=0x3FF -> 0x7BFF, no flag.
  - exp=0 -> 0x0000, unf_sticky=1.
  - exp=7'h7E (-2) -> 0x0000.
  - SAT_TO_INF=0 with exp=31 -> 0x7BFF, ovf_sticky=1.
- Backpressure, out_ready=0, DEPTH=2: push 4 words. Words 1-3 are accepted; in_ready=0 for word 4. Release out_ready=1: 8 bytes in order with no idle cycles between words.
- Reset mid-operation: rst for 1 cycle after the low byte of a word. Required: out_valid=0, busy=0, flags 0, FIFO empty, in_ready=1 in the next cycle. A fresh word 0x3C00 then streams 0x00, 0x3C.
